// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Rotates the request vector, priority-encodes it, then un-rotates.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IdxW-1:0]    ptr,
  output logic               any,
  output logic [IdxW-1:0]    idx
);

  logic [NUM_REQ-1:0] w_rot;
  logic               w_found;
  int                 w_src;
  int                 w_off;
  int                 w_sum;

  always_comb begin
    w_rot   = '0;
    w_found = 1'b0;
    w_src   = 0;
    w_off   = 0;
    w_sum   = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_src = int'(ptr) + k;
      if (w_src >= int'(NUM_REQ)) w_src = w_src - int'(NUM_REQ);
      w_rot[k] = req[w_src];
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_rot[k] && !w_found) begin
        w_found = 1'b1;
        w_off   = k;
      end
    end
    w_sum = int'(ptr) + w_off;
    if (w_sum >= int'(NUM_REQ)) w_sum = w_sum - int'(NUM_REQ);
    idx = IdxW'(w_sum);
    any = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-based round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATASIZE  = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATASIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_wfull,
  input  logic                          fifo_almost_full,
  output logic                          fifo_winc,
  output logic [DATASIZE-1:0]           fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          burst_done
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = cnt_w(BURST_LEN);

  arb_state_t    r_state, w_state_nxt;
  logic [IdxW-1:0] r_grant, w_grant_nxt;
  logic [IdxW-1:0] r_ptr, w_ptr_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;

  logic            w_any;
  logic [IdxW-1:0] w_pick;
  logic            w_sel_valid;
  logic            w_acc;
  logic [DATASIZE-1:0] w_slice [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_slice[i] = req_data[i*DATASIZE +: DATASIZE];
    end
  end

  assign fifo_wdata  = w_slice[r_grant];
  assign w_sel_valid = req_valid[r_grant];
  assign w_acc       = (r_state == BURST) && w_sel_valid && !fifo_wfull;
  assign grant_id    = r_grant;
  assign busy        = (r_state == BURST);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    req_ready   = '0;
    fifo_winc   = 1'b0;
    burst_done  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // almost_full only gates new grants; it never cuts a running burst.
        if (w_any && !fifo_almost_full) begin
          w_grant_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        req_ready[r_grant] = !fifo_wfull;
        fifo_winc          = w_acc;
        if (w_acc) w_cnt_nxt = r_cnt + CntW'(1);
        if ((w_acc && (r_cnt == CntW'(BURST_LEN - 1))) || !w_sel_valid) begin
          burst_done  = 1'b1;
          w_ptr_nxt   = (r_grant == IdxW'(NUM_REQ - 1)) ? '0 : r_grant + IdxW'(1);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a grant/beat-count reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_wfull;
  logic              fifo_almost_full;
  logic              fifo_winc;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              burst_done;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATASIZE  (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .fifo_wfull       (fifo_wfull),
    .fifo_almost_full (fifo_almost_full),
    .fifo_winc        (fifo_winc),
    .fifo_wdata       (fifo_wdata),
    .grant_id         (grant_id),
    .busy             (busy),
    .burst_done       (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: who owns the port, how many beats it has moved, where the scan starts.
  bit         m_busy;
  int         m_gid;
  int         m_beats;
  int         m_rr;
  logic [N-1:0] last_xfer;

  task automatic model_reset();
    m_busy    = 1'b0;
    m_gid     = 0;
    m_beats   = 0;
    m_rr      = 0;
    last_xfer = '0;
  endtask

  task automatic eval_and_check();
    logic [N-1:0]  e_ready;
    logic          e_winc;
    logic          e_done;
    logic [DW-1:0] e_data;
    e_ready = '0;
    e_winc  = 1'b0;
    e_done  = 1'b0;
    e_data  = req_data[m_gid*DW +: DW];
    if (m_busy) begin
      if (!fifo_wfull) e_ready[m_gid] = 1'b1;
      e_winc = req_valid[m_gid] && !fifo_wfull;
      e_done = !req_valid[m_gid] || (e_winc && (m_beats + 1 == BL));
    end
    check("grant_id",   32'(grant_id),   32'(m_gid));
    check("busy",       32'(busy),       32'(m_busy));
    check("req_ready",  32'(req_ready),  32'(e_ready));
    check("fifo_winc",  32'(fifo_winc),  32'(e_winc));
    check("burst_done", 32'(burst_done), 32'(e_done));
    check("fifo_wdata", 32'(fifo_wdata), 32'(e_data));
    last_xfer = req_valid & e_ready;
    if (m_busy) begin
      if (e_winc) m_beats++;
      if (e_done) begin
        m_busy = 1'b0;
        m_rr   = (m_gid + 1) % N;
      end
    end else if ((req_valid != '0) && !fifo_almost_full) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_valid[(m_rr + k) % N]) m_gid = (m_rr + k) % N;
      end
      m_beats = 0;
      m_busy  = 1'b1;
    end
  endtask

  task automatic check_reset_outputs();
    logic [DW-1:0] slice0;
    slice0 = req_data[DW-1:0];
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_ready",      32'(req_ready),  32'd0);
    check("rst_winc",       32'(fifo_winc),  32'd0);
    check("rst_done",       32'(burst_done), 32'd0);
    check("rst_grant",      32'(grant_id),   32'd0);
    check("rst_wdata",      32'(fifo_wdata), 32'(slice0));
  endtask

  // Producers hold valid/data until accepted, but may drop valid to model running dry.
  task automatic drive(input int vpct, input int wpct, input int apct, input int dpct);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || last_xfer[i]) begin
        req_valid[i] = ($urandom_range(99) < vpct);
        req_data[i*DW +: DW] = DW'($urandom);
      end else if ($urandom_range(99) < dpct) begin
        req_valid[i] = 1'b0;
      end
    end
    if (fifo_wfull) fifo_wfull = ($urandom_range(99) < 60);
    else            fifo_wfull = ($urandom_range(99) < wpct);
    fifo_almost_full = ($urandom_range(99) < apct);
  endtask

  int vpct [4] = '{100, 70, 90, 35};
  int wpct [4] = '{0,   15, 30, 10};
  int apct [4] = '{0,   20, 40, 10};
  int dpct [4] = '{0,   5,  15, 30};
  bit did_mid_rst;

  initial begin
    rst              = 1'b1;
    req_valid        = '0;
    req_data         = '0;
    fifo_wfull       = 1'b0;
    fifo_almost_full = 1'b0;
    did_mid_rst      = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        drive(vpct[p], wpct[p], apct[p], dpct[p]);
        #1;
        eval_and_check();
        if (p == 1 && !did_mid_rst && m_busy && m_beats == 1) begin
          did_mid_rst = 1'b1;
          rst = 1'b1;
          #1;
          check_reset_outputs();
          rst = 1'b0;
          model_reset();
          #1;
          eval_and_check();
        end
      end
    end
    check("mid_burst_reset_hit", 32'(did_mid_rst), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
